// File: rtl/thread_round_scheduler_if.sv
// thread_round_scheduler_if: issue-side bundle between the thread-state table, the scheduler and the engine issue logic
interface thread_round_scheduler_if #(
   parameter int N_CORES = 4,
   parameter int N_CTX   = 2,
   parameter int N_SEQ   = 2
);
   localparam int N_THREADS = N_CORES * N_CTX * N_SEQ;
   localparam int TW = (N_CORES > 1 ? $clog2(N_CORES) : 1) + $clog2(N_CTX) + $clog2(N_SEQ);
   logic [N_THREADS-1:0] ready_mask;
   logic                 advance;
   logic                 load_en;
   logic [TW-1:0]        load_num;
   logic [TW-1:0]        thread_num;
   logic                 thread_valid;
   logic                 wrap;
   modport master (output ready_mask, advance, load_en, load_num, input thread_num, thread_valid, wrap);
   modport slave  (input ready_mask, advance, load_en, load_num, output thread_num, thread_valid, wrap);
endinterface

// File: rtl/thread_round_scheduler.sv
// thread_round_scheduler: walks {core, ctx, seq} in issue order, skipping threads whose ready bit is clear
module thread_round_scheduler #(
   parameter int N_CORES = 4,
   parameter int N_CTX   = 2,
   parameter int N_SEQ   = 2
) (
   input logic CLK,
   input logic reset,
   thread_round_scheduler_if.slave bus
);
   localparam int CW = N_CORES > 1 ? $clog2(N_CORES) : 1;
   localparam int SW = $clog2(N_SEQ);
   localparam int TW = CW + $clog2(N_CTX) + SW;
   localparam int IW = TW - SW;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_CORES * N_CTX - 1);
   localparam logic [0:0] SCAN = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [TW-1:0] cand_q, cand_d, tn_q, tn_d, step_src, step_nxt, load_fix;
   logic          valid_q, valid_d, wrap_q, wrap_d, hit, step_wrap;
   logic [IW-1:0] in_idx;
   logic [SW-1:0] seq;
   // HOLD steps from the issued thread, SCAN from the candidate
   assign step_src  = state_q == HOLD ? tn_q : cand_q;
   assign in_idx    = step_src[TW-1:SW];
   assign seq       = step_src[SW-1:0];
   assign step_nxt  = in_idx == LAST_IDX ? {IW'(0), SW'(seq + 1'b1)} : {IW'(in_idx + 1'b1), seq};
   assign step_wrap = in_idx == LAST_IDX && seq == '1;
   assign hit       = bus.ready_mask[cand_q];
   assign load_fix  = int'(bus.load_num[TW-1 -: CW]) >= N_CORES ? '0 : bus.load_num;
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      tn_d    = tn_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      if (bus.load_en) begin
         cand_d  = load_fix;
         valid_d = 1'b0;
         state_d = SCAN;
      end else if (state_q == SCAN) begin
         tn_d    = hit ? cand_q : tn_q;
         valid_d = hit;
         state_d = hit ? HOLD : SCAN;
         cand_d  = hit ? cand_q : step_nxt;
         wrap_d  = !hit && step_wrap;
      end else if (bus.advance) begin
         cand_d  = step_nxt;
         wrap_d  = step_wrap;
         valid_d = 1'b0;
         state_d = SCAN;
      end
   end
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= SCAN;
         cand_q  <= '0;
         tn_q    <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         tn_q    <= tn_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end
   assign bus.thread_num   = tn_q;
   assign bus.thread_valid = valid_q;
   assign bus.wrap         = wrap_q;
endmodule
